// File: rtl/color_scan_arbiter.sv
// Round-robin arbiter sharing one color detector among four sensor heads.
// Optional WAIT_DONE watchdog is enabled by defining SCAN_TIMEOUT_EN.
module color_scan_arbiter #(
    parameter logic [15:0] SETTLE_CYCLES  = 16'd1000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] ack,
    output logic [1:0] result_color,
    output logic       result_err,
    output logic       det_start,
    input  logic       det_complete,
    input  logic [1:0] det_color,
    output logic [1:0] sensor_sel,
    output logic       led_en,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  sel_q, sel_d;
    logic        led_q, led_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic [1:0]  color_q, color_d;
    logic [1:0]  rr_idx;
    logic [1:0]  cand;
`ifdef SCAN_TIMEOUT_EN
    logic        err_q, err_d;
    logic [23:0] wdog_q, wdog_d;
`endif

    // Descending scan so the candidate nearest last_grant+1 is assigned last and wins.
    always_comb begin
        rr_idx = '0;
        cand   = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            cand = last_grant_q + 2'(i);
            if (req[cand]) begin
                rr_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            sel_q        <= '0;
            led_q        <= 1'b0;
            settle_cnt_q <= '0;
            color_q      <= '0;
`ifdef SCAN_TIMEOUT_EN
            err_q        <= 1'b0;
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            led_q        <= led_d;
            settle_cnt_q <= settle_cnt_d;
            color_q      <= color_d;
`ifdef SCAN_TIMEOUT_EN
            err_q        <= err_d;
            wdog_q       <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        led_d        = led_q;
        settle_cnt_d = settle_cnt_q;
        color_d      = color_q;
`ifdef SCAN_TIMEOUT_EN
        err_d        = err_q;
        wdog_d       = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    sel_d        = rr_idx;
                    led_d        = 1'b1;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_CYCLES - 16'd1) begin
                    state_d = START;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            START: begin
`ifdef SCAN_TIMEOUT_EN
                // The START cycle counts toward the watchdog window.
                wdog_d = 24'd1;
`endif
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (det_complete) begin
                    color_d = det_color;
`ifdef SCAN_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESPOND;
                end
`ifdef SCAN_TIMEOUT_EN
                else if (wdog_q >= TIMEOUT_CYCLES - 24'd1) begin
                    color_d = 2'b00;
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
`endif
            end
            RESPOND: begin
                last_grant_d = sel_q;
                led_d        = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack          = (state_q == RESPOND) ? (4'b0001 << sel_q) : '0;
        det_start    = (state_q == START);
        busy         = (state_q != IDLE);
        sensor_sel   = sel_q;
        led_en       = led_q;
        result_color = color_q;
`ifdef SCAN_TIMEOUT_EN
        result_err   = err_q;
`else
        result_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_color_scan_arbiter.sv
// Directed bench for color_scan_arbiter with a scoreboard of expected acks.
// Timeout scenario runs only when SCAN_TIMEOUT_EN is defined.
module tb_color_scan_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] result_color;
    logic       result_err;
    logic       det_start;
    logic       det_complete;
    logic [1:0] det_color;
    logic [1:0] sensor_sel;
    logic       led_en;
    logic       busy;

    typedef struct packed {
        logic [3:0] ack;
        logic [1:0] color;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [1:0] cur_grant;

    always #5 clk = ~clk;

    color_scan_arbiter #(
        .SETTLE_CYCLES (16'd4),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .result_color(result_color),
        .result_err  (result_err),
        .det_start   (det_start),
        .det_complete(det_complete),
        .det_color   (det_color),
        .sensor_sel  (sensor_sel),
        .led_en      (led_en),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_det_start", det_start, 1'b0);
        chk("rst_led", led_en, 1'b0);
        chk("rst_sel", sensor_sel, 2'd0);
        chk("rst_color", result_color, 2'd0);
        chk("rst_err", result_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge one cycle after det_start.
    task automatic start_scan(input logic [3:0] r, input bit drop, input logic [1:0] exp_grant);
        int k;
        k = 0;
        req = r;
        cur_grant = exp_grant;
        do begin
            @(negedge clk);
            k++;
            if (drop) req = '0;
        end while (det_start !== 1'b1 && k < 50);
        chk("start_latency", k, 5);
        chk("sensor_sel", sensor_sel, exp_grant);
        chk("led_on", led_en, 1'b1);
        @(negedge clk);
        chk("start_one_shot", det_start, 1'b0);
        chk("busy_wait", busy, 1'b1);
    endtask

    task automatic check_ack();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ack", ack, e.ack);
            chk("result_color", result_color, e.color);
            chk("result_err", result_err, e.err);
            @(negedge clk);
            chk("ack_pulse", ack, 4'b0000);
            chk("led_off", led_en, 1'b0);
            chk("busy_idle", busy, 1'b0);
            chk("color_hold", result_color, e.color);
        end
    endtask

    // dly = cycles from det_start to ack (>= 2).
    task automatic finish_scan(input int dly, input logic [1:0] col);
        exp_t e;
        repeat (dly - 2) @(negedge clk);
        chk("no_early_ack", ack, 4'b0000);
        det_color    = col;
        det_complete = 1'b1;
        e.ack   = 4'b0001 << cur_grant;
        e.color = col;
        e.err   = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        det_complete = 1'b0;
        det_color    = 2'b00;
        check_ack();
    endtask

    initial begin
        logic [1:0] cols[5];
        reset        = 1'b1;
        req          = '0;
        det_complete = 1'b0;
        det_color    = '0;
        cols = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01};

        do_reset();

        // Stray completion while idle
        det_color    = 2'b11;
        det_complete = 1'b1;
        @(negedge clk);
        det_complete = 1'b0;
        chk("idle_cmpl_ack", ack, 4'b0000);
        chk("idle_cmpl_busy", busy, 1'b0);
        chk("idle_cmpl_color", result_color, 2'b00);
        @(negedge clk);

        // Single one-cycle request
        start_scan(4'b0001, 1'b1, 2'd0);
        finish_scan(5, 2'b10);

        // All requesters held: full rotation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            start_scan(4'b1111, 1'b0, 2'(i % 4));
            finish_scan(3 + i, cols[i]);
        end
        req = '0;

        // Sparse requesters held
        do_reset();
        start_scan(4'b0101, 1'b0, 2'd0);
        finish_scan(4, 2'b01);
        start_scan(4'b0101, 1'b0, 2'd2);
        finish_scan(2, 2'b11);
        start_scan(4'b0101, 1'b0, 2'd0);
        finish_scan(6, 2'b10);
        req = '0;
        @(negedge clk);

        // Reset while waiting for the detector
        start_scan(4'b0100, 1'b1, 2'd2);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_led", led_en, 1'b0);
        chk("midrst_sel", sensor_sel, 2'd0);
        chk("midrst_ack", ack, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        det_color    = 2'b10;
        det_complete = 1'b1;
        @(negedge clk);
        det_complete = 1'b0;
        chk("midrst_cmpl_ack", ack, 4'b0000);
        chk("midrst_cmpl_busy", busy, 1'b0);
        start_scan(4'b0010, 1'b1, 2'd1);
        finish_scan(3, 2'b01);

`ifdef SCAN_TIMEOUT_EN
        begin
            exp_t e;
            int   k;
            start_scan(4'b1000, 1'b1, 2'd3);
            e.ack   = 4'b1000;
            e.color = 2'b00;
            e.err   = 1'b1;
            sb.push_back(e);
            k = 1;
            while (ack === 4'b0000 && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk("timeout_latency", k, 100);
            check_ack();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/color_scan_arbiter.md
COLOR_SCAN_ARBITER -- requirements
Module: color_scan_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16'd1000, illumination/mux settle time in clk cycles before each detection (minimum 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd10000000, WAIT_DONE watchdog limit in clk cycles (used only when SCAN_TIMEOUT_EN is defined).
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req  in  4  per-requester scan request, level.
REQ-006 ack  out  4  one-hot, one-cycle pulse: result valid for that requester.
REQ-007 result_color  out  2  detected color (00 red, 01 green, 10 blue, 11 yellow), valid while ack nonzero.
REQ-008 result_err  out  1  scan timed out, valid while ack nonzero.
REQ-009 det_start  out  1  one-cycle start pulse to the shared color detector.
REQ-010 det_complete  in  1  one-cycle completion pulse from the detector.
REQ-011 det_color  in  2  detector color, valid with det_complete.
REQ-012 sensor_sel  out  2  sensor-head mux select = granted requester index.
REQ-013 led_en  out  1  sensor illumination enable.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, SETTLE, START, WAIT_DONE, RESPOND.
REQ-016 IDLE: if req != 0, grant the round-robin winner, latch index into sensor_sel, set led_en=1, clear settle counter, go SETTLE; else remain.
REQ-017 Round-robin: search begins at (last_grant+1) mod 4, ascending with wrap; last_grant updates to the granted index in RESPOND.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go START.
REQ-019 START SHALL assert det_start for exactly one cycle, then go WAIT_DONE.
REQ-020 WAIT_DONE: on det_complete=1, latch det_color, clear error flag, go RESPOND.
REQ-021 RESPOND (one cycle): ack[granted]=1, result_color/result_err driven from latches, led_en<=0, go IDLE.
REQ-022 Latency: req sampled high in IDLE at edge T -> det_start high during cycle T+1+SETTLE_CYCLES; det_complete sampled at edge E -> ack high during cycle after E.
REQ-023 Requests not re-sampled outside IDLE; req deasserted mid-scan SHALL NOT abort: scan completes, ack still issued.
REQ-024 req still high in IDLE after ack SHALL be treated as a new request (requester drops req on ack).
REQ-025 det_complete outside WAIT_DONE SHALL be ignored.
REQ-026 ack, det_start 0 in all states other than RESPOND/START respectively; result_color/result_err hold last values otherwise.

Reset
REQ-027 reset SHALL force IDLE, last_grant=3 (requester 0 first), ack=0, det_start=0, led_en=0, sensor_sel=0, result_color=0, result_err=0, counters 0, from any state including mid-scan.

Configuration
REQ-028 SCAN_TIMEOUT_EN defined: WAIT_DONE counts cycles; at TIMEOUT_CYCLES without det_complete, go RESPOND with result_color=00, result_err=1; det_complete on the same cycle as expiry takes priority (normal result).
REQ-029 SCAN_TIMEOUT_EN undefined: no watchdog; WAIT_DONE waits indefinitely; result_err tied 0.

Verification (SETTLE_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-030 req=0001 one cycle, det_complete with det_color=10 5 cycles after det_start -> det_start 5 cycles after req edge, ack=0001, result_color=10, result_err=0, led_en low after ack.
REQ-031 req=1111 held, each scan completed -> ack order 0001,0010,0100,1000,0001.
REQ-032 req=0101 held after reset -> grants 0 then 2 then 0; sensor_sel matches grant each scan.
REQ-033 SCAN_TIMEOUT_EN, det_complete never arrives -> ack pulse 100 cycles after det_start, result_err=1, result_color=00.
REQ-034 reset asserted during WAIT_DONE, then det_complete pulse -> no ack, busy=0, led_en=0, next req=0010 grants requester 1 normally.
REQ-035 det_complete pulsed while IDLE -> no ack, state unchanged.
